// File: rtl/coin_change_dispenser.sv
// Coin payout engine: pays a nickel-unit refund in dimes first, then nickels, tracking stock; DISPENSE_AUDIT_EN adds a paid_total counter.
// Latency: first coin pulse in the cycle after accept, PULSE_GAP idle cycles between pulses, done one cycle after the last decision.
// Backpressure: refund_ready is high only in IDLE; requests presented while busy are ignored, never queued.
module coin_change_dispenser #(
  parameter int AMOUNT_W    = 5,
  parameter int STOCK_W     = 5,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int PULSE_GAP   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                refund_valid,
  input  logic [AMOUNT_W-1:0] refund_amount,
  output logic                refund_ready,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                busy,
  output logic                done,
  output logic                short_change,
  output logic [AMOUNT_W-1:0] remaining,
  input  logic                restock_nickel,
  input  logic                restock_dime,
  output logic [STOCK_W-1:0]  nickel_stock,
  output logic [STOCK_W-1:0]  dime_stock
`ifdef DISPENSE_AUDIT_EN
  ,
  output logic [15:0]         paid_total
`endif
);

  typedef enum logic [1:0] {IDLE, PAY, GAP, DONE} state_t;

  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

  state_t state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic accept;
  logic pay_end;

  // Saturating add on restock; a same-cycle restock and dispense cancel out.
  function automatic logic [STOCK_W-1:0] stock_upd(input logic [STOCK_W-1:0] s,
                                                  input logic add, input logic sub);
    logic [STOCK_W-1:0] r;
    r = s;
    if (add && !sub && (s != STOCK_MAX)) r = s + STOCK_W'(1);
    else if (sub && !add)                r = s - STOCK_W'(1);
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    refund_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    dime_out     = 1'b0;
    nickel_out   = 1'b0;
    accept       = 1'b0;
    pay_end      = 1'b0;
    unique case (state)
      IDLE: begin
        refund_ready = 1'b1;
        busy         = 1'b0;
        if (refund_valid) begin
          accept    = 1'b1;
          state_nxt = PAY;
        end
      end
      PAY: begin
        // Pulses decode from registered state/stock, so they are glitch-free and input-independent.
        if (remaining == '0) begin
          pay_end   = 1'b1;
          state_nxt = DONE;
        end else if ((remaining >= AMOUNT_W'(2)) && (dime_stock != '0)) begin
          dime_out  = 1'b1;
          state_nxt = (PULSE_GAP > 0) ? GAP : PAY;
        end else if (nickel_stock != '0) begin
          nickel_out = 1'b1;
          state_nxt  = (PULSE_GAP > 0) ? GAP : PAY;
        end else begin
          pay_end   = 1'b1;
          state_nxt = DONE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = PAY;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      remaining    <= '0;
      short_change <= 1'b0;
      gap_cnt      <= '0;
      nickel_stock <= STOCK_W'(NICKEL_INIT);
      dime_stock   <= STOCK_W'(DIME_INIT);
    end else begin
      if (accept) begin
        remaining    <= refund_amount;
        short_change <= 1'b0;
      end else if (dime_out) begin
        remaining <= remaining - AMOUNT_W'(2);
      end else if (nickel_out) begin
        remaining <= remaining - AMOUNT_W'(1);
      end
      if (pay_end) short_change <= (remaining != '0);
      gap_cnt      <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      nickel_stock <= stock_upd(nickel_stock, restock_nickel, nickel_out);
      dime_stock   <= stock_upd(dime_stock, restock_dime, dime_out);
    end
  end

`ifdef DISPENSE_AUDIT_EN
  always_ff @(posedge clock) begin
    if (!reset)          paid_total <= '0;
    else if (dime_out)   paid_total <= paid_total + 16'd2;
    else if (nickel_out) paid_total <= paid_total + 16'd1;
  end
`endif

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser with default parameters (PULSE_GAP=1, stocks 8/8).
// Expected pulse masks are bit-per-cycle after the accept edge, computed by hand.
module tb_coin_change_dispenser;

  logic        clock = 1'b0;
  logic        reset;
  logic        refund_valid;
  logic [4:0]  refund_amount;
  logic        refund_ready;
  logic        nickel_out;
  logic        dime_out;
  logic        busy;
  logic        done;
  logic        short_change;
  logic [4:0]  remaining;
  logic        restock_nickel;
  logic        restock_dime;
  logic [4:0]  nickel_stock;
  logic [4:0]  dime_stock;
`ifdef DISPENSE_AUDIT_EN
  logic [15:0] paid_total;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] dm, nm;
  int          dcyc, rlow;

  coin_change_dispenser dut (
    .clock          (clock),
    .reset          (reset),
    .refund_valid   (refund_valid),
    .refund_amount  (refund_amount),
    .refund_ready   (refund_ready),
    .nickel_out     (nickel_out),
    .dime_out       (dime_out),
    .busy           (busy),
    .done           (done),
    .short_change   (short_change),
    .remaining      (remaining),
    .restock_nickel (restock_nickel),
    .restock_dime   (restock_dime),
    .nickel_stock   (nickel_stock),
    .dime_stock     (dime_stock)
`ifdef DISPENSE_AUDIT_EN
    ,
    .paid_total     (paid_total)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one request, holds refund_valid with a junk amount while busy, and records pulses per cycle.
  task automatic run_req(input logic [4:0] amt, output logic [31:0] dmask, output logic [31:0] nmask,
                         output int done_cyc, output int ready_low);
    logic excl;
    dmask = '0; nmask = '0; done_cyc = 0; ready_low = 0; excl = 1'b0;
    refund_valid  = 1'b1;
    refund_amount = amt;
    step();
    refund_amount = 5'd31;
    for (int c = 1; c <= 60; c++) begin
      if (c < 32 && dime_out)   dmask[c] = 1'b1;
      if (c < 32 && nickel_out) nmask[c] = 1'b1;
      if (!refund_ready) ready_low++;
      if (dime_out && nickel_out) excl = 1'b1;
      if (done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    refund_valid = 1'b0;
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    check("exclusive", 32'(excl), 32'd0);
    step();
    check("ready_after", 32'(refund_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; refund_valid = 1'b0; refund_amount = '0;
    restock_nickel = 1'b0; restock_dime = 1'b0;
    step(); step();
    check("rst_ready", 32'(refund_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({dime_out, nickel_out, done}), 32'd0);
    check("rst_short", 32'(short_change), 32'd0);
    check("rst_rem", 32'(remaining), 32'd0);
    check("rst_nstock", 32'(nickel_stock), 32'd8);
    check("rst_dstock", 32'(dime_stock), 32'd8);
    reset = 1'b1;
    step();

    run_req(5'd7, dm, nm, dcyc, rlow);
    check("r7_dimes", dm, 32'h2A);
    check("r7_nickels", nm, 32'h80);
    check("r7_done_cyc", 32'(dcyc), 32'd10);
    check("r7_short", 32'(short_change), 32'd0);
    check("r7_rem", 32'(remaining), 32'd0);
    check("r7_dstock", 32'(dime_stock), 32'd5);
    check("r7_nstock", 32'(nickel_stock), 32'd7);
`ifdef DISPENSE_AUDIT_EN
    check("r7_audit", 32'(paid_total), 32'd7);
`endif

    run_req(5'd10, dm, nm, dcyc, rlow);
    check("r10_dimes", dm, 32'h2AA);
    check("r10_nickels", nm, 32'h0);
    check("r10_done_cyc", 32'(dcyc), 32'd12);
    check("r10_dstock", 32'(dime_stock), 32'd0);

    run_req(5'd3, dm, nm, dcyc, rlow);
    check("r3_dimes", dm, 32'h0);
    check("r3_nickels", nm, 32'h2A);
    check("r3_done_cyc", 32'(dcyc), 32'd8);
    check("r3_short", 32'(short_change), 32'd0);
    check("r3_nstock", 32'(nickel_stock), 32'd4);

    run_req(5'd4, dm, nm, dcyc, rlow);
    check("r4_nickels", nm, 32'hAA);
    check("r4_nstock", 32'(nickel_stock), 32'd0);

    restock_dime = 1'b1;
    step();
    restock_dime = 1'b0;
    check("restock_one", 32'(dime_stock), 32'd1);

    run_req(5'd3, dm, nm, dcyc, rlow);
    check("short_dimes", dm, 32'h2);
    check("short_nickels", nm, 32'h0);
    check("short_done_cyc", 32'(dcyc), 32'd4);
    check("short_flag", 32'(short_change), 32'd1);
    check("short_rem", 32'(remaining), 32'd1);
    check("short_dstock", 32'(dime_stock), 32'd0);

    run_req(5'd0, dm, nm, dcyc, rlow);
    check("zero_pulses", dm | nm, 32'h0);
    check("zero_done_cyc", 32'(dcyc), 32'd2);
    check("zero_ready_low", 32'(rlow), 32'd2);
    check("zero_short", 32'(short_change), 32'd0);
    check("zero_rem", 32'(remaining), 32'd0);

    restock_dime = 1'b1;
    step(); step(); step();
    check("rs_pre", 32'(dime_stock), 32'd3);
    refund_valid = 1'b1; refund_amount = 5'd4;
    step();
    refund_valid = 1'b0;
    check("rs_c1_pulse", 32'(dime_out), 32'd1);
    check("rs_c1_stock", 32'(dime_stock), 32'd4);
    step();
    check("rs_c2_stock", 32'(dime_stock), 32'd4);
    step();
    check("rs_c3_pulse", 32'(dime_out), 32'd1);
    check("rs_c3_stock", 32'(dime_stock), 32'd5);
    step();
    check("rs_c4_stock", 32'(dime_stock), 32'd5);
    step();
    restock_dime = 1'b0;
    step();
    check("rs_done", 32'(done), 32'd1);
    check("rs_final", 32'(dime_stock), 32'd6);
    step();

    restock_dime = 1'b1;
    repeat (40) step();
    restock_dime = 1'b0;
    check("sat_dime", 32'(dime_stock), 32'd31);
`ifdef DISPENSE_AUDIT_EN
    check("audit_pre", 32'(paid_total), 32'd30);
`endif

    refund_valid = 1'b1; refund_amount = 5'd10;
    step();
    refund_valid = 1'b0;
    step(); step();
    check("mid_pulse", 32'(dime_out), 32'd1);
    reset = 1'b0;
    step();
    check("abort_pulses", 32'({dime_out, nickel_out}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(refund_ready), 32'd1);
    check("abort_nstock", 32'(nickel_stock), 32'd8);
    check("abort_dstock", 32'(dime_stock), 32'd8);
    check("abort_rem", 32'(remaining), 32'd0);
`ifdef DISPENSE_AUDIT_EN
    check("abort_audit", 32'(paid_total), 32'd0);
`endif
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
- Payout-side counterpart to the vending machine coin-acceptor FSMs.
- Takes a refund or change request expressed in nickel units.
- Drives coin-ejector pulses, preferring dimes and falling back to nickels.
- Tracks on-board dime and nickel inventory, and reports short-change when stock cannot cover a request.

Parameters:
AMOUNT_W, 5, width of refund amount and remaining count, in nickel units (5 cents each)
STOCK_W, 5, width of each coin inventory counter
NICKEL_INIT, 8, nickel stock loaded at reset
DIME_INIT, 8, dime stock loaded at reset
PULSE_GAP, 1, idle cycles inserted after each coin pulse (0 = back-to-back)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
refund_valid  in  1  request present
refund_amount  in  AMOUNT_W  change owed, in nickel units
refund_ready  out  1  high only in IDLE; request accepted when refund_valid && refund_ready at a clock edge
nickel_out  out  1  one-cycle pulse = eject one nickel
dime_out  out  1  one-cycle pulse = eject one dime
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a request completes
short_change  out  1  valid with done: 1 = request not fully paid
remaining  out  AMOUNT_W  unpaid nickel units; valid with done, holds until next accept
restock_nickel  in  1  add one nickel to stock this cycle
restock_dime  in  1  add one dime to stock this cycle
nickel_stock  out  STOCK_W  current nickel inventory
dime_stock  out  STOCK_W  current dime inventory

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; all pulse outputs, busy, short_change and remaining are 0.
  - nickel_stock=NICKEL_INIT and dime_stock=DIME_INIT.
  - Reset mid-payout aborts immediately with no further pulses.
- States: IDLE, PAY, GAP, DONE.
- IDLE:
  - refund_ready=1.
  - On accept, latch refund_amount into remaining and go to PAY. The first coin pulse appears in the cycle after the accept edge.
- PAY (one decision per cycle, registered outputs, priority order):
  - remaining==0 -> DONE, short_change=0.
  - remaining>=2 and dime_stock>0 -> dime_out=1, remaining-=2, dime_stock-=1.
  - remaining>=1 and nickel_stock>0 -> nickel_out=1, remaining-=1, nickel_stock-=1.
  - Otherwise -> DONE, short_change=1, remaining holds the unpaid amount.
  - After any pulse: go to GAP if PULSE_GAP>0, else stay in PAY.
- GAP: count PULSE_GAP cycles with no pulses, then return to PAY.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - short_change and remaining hold until the next accept.
- Exclusivity: nickel_out and dime_out are never high in the same cycle.
- Zero-amount request: no pulses; done in the 2nd cycle after accept, short_change=0.
- Odd remainders: remaining==1 with no nickels ends short (remaining=1) even if dimes are in stock. The block never overpays.
- Restock:
  - Accepted in any state, including during a payout.
  - Each counter saturates at 2^STOCK_W-1.
  - Restock and dispense of the same coin type in the same cycle gives a net change of 0.
  - A coin restocked during a payout is usable from the next PAY decision.
- refund_valid is ignored while busy; requests are not queued.

Optional Feature:
- Macro: DISPENSE_AUDIT_EN.
- When defined:
  - Adds output port paid_total (16 bits).
  - Counts total nickel units ejected since reset: +1 per nickel_out, +2 per dime_out.
  - Wraps modulo 2^16 and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then request 7 with defaults (PULSE_GAP=1) -> dime pulses in cycles 1, 3, 5, nickel pulse in cycle 7 after accept; done with short_change=0, remaining=0; stocks dime=5, nickel=7.
- dime_stock driven to 0 via prior payouts, request 3 -> three nickel pulses, done, short_change=0.
- Stocks nickel=0, dime=1, request 3 -> one dime pulse, then done with short_change=1, remaining=1.
- Request 0 -> no pulses; done 2 cycles after accept; refund_ready low for exactly 2 cycles.
- restock_dime held high while dispensing dimes -> dime_stock unchanged in pulse cycles; restock with stock at 31 (STOCK_W=5) stays 31.
- reset=0 asserted mid-payout of request 10 -> next cycle: no pulses, busy=0, refund_ready=1, stocks back to 8/8. With DISPENSE_AUDIT_EN, paid_total returns to 0.
